// File: rtl/xor_fold_encoder.sv
// xor_fold_encoder: packs 56-bit payloads into 64-bit frames with a chained XOR-fold check byte
module xor_fold_encoder #(
  parameter bit         CHAIN_EN = 1'b1,
  parameter logic [7:0] SEED     = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [55:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_last,
  output logic [15:0] frame_count,
  output logic        busy
);
  logic [64:0] mem_q [2];
  logic [64:0] mem_d [2];
  logic        rd_q, rd_d, wr_q, wr_d;
  logic [1:0]  count_q, count_d;
  logic [7:0]  chain_q, chain_d, fold, check;
  logic        in_ready_q, in_ready_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic        push, pop;
  logic [64:0] head;
  always_comb begin
    fold = in_data[55:48] ^ in_data[47:40] ^ in_data[39:32] ^ in_data[31:24] ^
           in_data[23:16] ^ in_data[15:8] ^ in_data[7:0];
    check = fold ^ (CHAIN_EN ? chain_q : 8'h00);
    push = in_valid && in_ready_q;
    pop = out_valid && out_ready;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {in_data, check, in_last};
    rd_d = rd_q ^ pop;
    wr_d = wr_q ^ push;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    in_ready_d = count_d < 2'd2;
    chain_d = push ? (in_last ? SEED : check) : chain_q;
    frame_count_d = pop ? frame_count_q + 16'd1 : frame_count_q;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      count_q <= 2'd0;
      in_ready_q <= 1'b0;
      chain_q <= SEED;
      frame_count_q <= 16'd0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      in_ready_q <= in_ready_d;
      chain_q <= chain_d;
      frame_count_q <= frame_count_d;
    end
  end
  always_comb begin
    head = mem_q[rd_q];
    out_valid = count_q != 2'd0;
    out_data = out_valid ? head[64:1] : 64'd0;
    out_last = out_valid && head[0];
    busy = out_valid;
    in_ready = in_ready_q;
    frame_count = frame_count_q;
  end
endmodule

// File: tb/tb_xor_fold_encoder.sv
// tb_xor_fold_encoder: directed-vector bench for chained and unchained encoder instances
module tb_xor_fold_encoder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [55:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_last, busy;
  logic [63:0] out_data;
  logic [15:0] frame_count;
  logic        in_ready0, out_valid0, out_last0, busy0;
  logic [63:0] out_data0;
  logic [15:0] frame_count0;
  int          vectors = 0;
  int          miscompares = 0;
  logic [55:0] pay [3] = '{56'h11, 56'h22, 56'h33};

  xor_fold_encoder #(.CHAIN_EN(1'b1), .SEED(8'h00)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .frame_count(frame_count), .busy(busy)
  );

  xor_fold_encoder #(.CHAIN_EN(1'b0), .SEED(8'h00)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .out_last(out_last0), .frame_count(frame_count0), .busy(busy0)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (frame_count !== 16'd0) begin miscompares++; $display("FAIL reset_frame_count got %h want 0000", frame_count); end
    vectors++; if (out_data !== 64'd0 || out_last !== 1'b0) begin miscompares++; $display("FAIL reset_out_data got %h/%b want 0/0", out_data, out_last); end
    reset = 1'b0;
    step();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b0; in_data = 'x;
    step();
    vectors++; if (out_valid !== 1'b0 || frame_count !== 16'd0) begin miscompares++; $display("FAIL idle_x got valid %b count %h want 0/0000", out_valid, frame_count); end
    in_valid = 1'b1; in_data = 56'h01; in_last = 1'b0;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
    vectors++; if (out_data !== 64'h0101) begin miscompares++; $display("FAIL single_data got %h want %h", out_data, 64'h0101); end
    step();
    vectors++; if (frame_count !== 16'd1) begin miscompares++; $display("FAIL single_count got %h want 0001", frame_count); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_chain();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 56'h01; in_last = 1'b0;
    step();
    vectors++; if (out_data !== 64'h0101) begin miscompares++; $display("FAIL chain_first got %h want %h", out_data, 64'h0101); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_data !== 64'h0100) begin miscompares++; $display("FAIL chain_second got %h want %h", out_data, 64'h0100); end
    vectors++; if (frame_count !== 16'd1 || out_valid !== 1'b1) begin miscompares++; $display("FAIL chain_overlap got count %h valid %b want 0001/1", frame_count, out_valid); end
    step();
    vectors++; if (frame_count !== 16'd2) begin miscompares++; $display("FAIL chain_count got %h want 0002", frame_count); end
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 56'h01; in_last = 1'b1;
    step();
    vectors++; if (out_data !== 64'h0101 || out_last !== 1'b1) begin miscompares++; $display("FAIL last_first got %h/%b want %h/1", out_data, out_last, 64'h0101); end
    in_last = 1'b0;
    step();
    in_valid = 1'b0;
    vectors++; if (out_data !== 64'h0101 || out_last !== 1'b0) begin miscompares++; $display("FAIL last_restart got %h/%b want %h/0", out_data, out_last, 64'h0101); end
    step();
  endtask

  task automatic test_nochain();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 56'h01_02_03_04_05_06_07; in_last = 1'b0;
    step();
    vectors++; if (out_data0 !== 64'h0102_0304_0506_0700) begin miscompares++; $display("FAIL nochain_zero got %h want %h", out_data0, 64'h0102_0304_0506_0700); end
    in_data = 56'hFF;
    step();
    in_valid = 1'b0;
    vectors++; if (out_data0 !== 64'h0000_0000_0000_FFFF) begin miscompares++; $display("FAIL nochain_ff got %h want %h", out_data0, 64'h0000_0000_0000_FFFF); end
    in_data = 56'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (out_data0 !== 64'h0101) begin miscompares++; $display("FAIL nochain_repeat got %h want %h", out_data0, 64'h0101); end
    step();
  endtask

  task automatic test_backpressure();
    int   acc;
    logic took;
    do_reset();
    acc = 0; out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_data = pay[acc];
      took = in_ready;
      step();
      if (took) acc++;
    end
    vectors++; if (acc !== 2) begin miscompares++; $display("FAIL bp_accepts got %0d want 2", acc); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    vectors++; if (out_data !== 64'h1111) begin miscompares++; $display("FAIL bp_hold got %h want %h", out_data, 64'h1111); end
    out_ready = 1'b1; in_data = pay[2];
    step();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_pop_ready got %b want 1", in_ready); end
    vectors++; if (out_data !== 64'h2233) begin miscompares++; $display("FAIL bp_second got %h want %h", out_data, 64'h2233); end
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b0 || out_data !== 64'h2233) begin miscompares++; $display("FAIL bp_refill got ready %b data %h want 0/%h", in_ready, out_data, 64'h2233); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_data !== 64'h3300) begin miscompares++; $display("FAIL bp_third got %h want %h", out_data, 64'h3300); end
    step();
    vectors++; if (out_valid !== 1'b0 || frame_count !== 16'd3) begin miscompares++; $display("FAIL bp_drain got valid %b count %h want 0/0003", out_valid, frame_count); end
  endtask

  task automatic test_stream();
    int emits;
    do_reset();
    emits = 0; out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_data = 56'(i);
      if (out_valid) begin
        vectors++; if (out_data[63:8] !== 56'(emits)) begin miscompares++; $display("FAIL stream_order got %h want %h", out_data[63:8], 56'(emits)); end
        emits++;
      end
      step();
    end
    in_valid = 1'b0;
    vectors++; if (emits !== 99) begin miscompares++; $display("FAIL stream_emits got %0d want 99", emits); end
    vectors++; if (frame_count !== 16'd99) begin miscompares++; $display("FAIL stream_count got %h want 0063", frame_count); end
    step();
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 56'h5A; in_last = 1'b0;
    for (int i = 0; i < 65534; i++) step();
    in_valid = 1'b0;
    step();
    vectors++; if (frame_count !== 16'hFFFE) begin miscompares++; $display("FAIL wrap_preload got %h want fffe", frame_count); end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    in_valid = 1'b0;
    step();
    vectors++; if (frame_count !== 16'h0001) begin miscompares++; $display("FAIL wrap_count got %h want 0001", frame_count); end
  endtask

  task automatic test_reset_midburst();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b0; in_data = 56'h11;
    step();
    in_valid = 1'b0;
    step();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 56'h22;
    step();
    in_data = 56'h44;
    step();
    vectors++; if (in_ready !== 1'b0 || busy !== 1'b1 || frame_count !== 16'd1) begin miscompares++; $display("FAIL mid_full got ready %b busy %b count %h want 0/1/0001", in_ready, busy, frame_count); end
    reset = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0 || frame_count !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset got valid %b count %h busy %b ready %b want 0/0000/0/0", out_valid, frame_count, busy, in_ready); end
    reset = 1'b0; in_valid = 1'b0;
    step();
    vectors++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_release got ready %b valid %b want 1/0", in_ready, out_valid); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 56'h01;
    step();
    in_valid = 1'b0;
    vectors++; if (out_data !== 64'h0101) begin miscompares++; $display("FAIL mid_seed got %h want %h", out_data, 64'h0101); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_chain();
    test_nochain();
    test_backpressure();
    test_stream();
    test_wrap();
    test_reset_midburst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/xor_fold_encoder.md
Name: xor_fold_encoder

Overview:
Streaming encoder. Each 56-bit payload becomes a 64-bit frame whose low byte is an XOR-folded check byte, optionally chained across frames. It is the transmit end of the XOR-field check path: it produces the frames that the downstream XOR-field checker recomputes and compares against. Valid/ready on both sides, with a 2-entry output buffer.

Parameters:
CHAIN_EN, 1, 1 = check byte also XORs the previous frame's check byte; 0 = check byte is the plain fold of the payload.
SEED, 8'h00, initial chain value; chain returns to it after reset and after every in_last frame.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  payload valid
in_ready  output  1  encoder can accept a payload (registered)
in_data  input  56  payload
in_last  input  1  last payload of a burst; chain restarts after it
out_valid  output  1  frame valid
out_ready  input  1  downstream accepts frame
out_data  output  64  {payload[55:0], check[7:0]}
out_last  output  1  copy of in_last for this frame
frame_count  output  16  number of frames accepted downstream
busy  output  1  buffer not empty

Behaviour:
- Accept: in_valid & in_ready on a rising edge. Emit: out_valid & out_ready on a rising edge.
- Fold: fold = XOR of the 7 payload bytes, in_data[55:48] ^ ... ^ in_data[7:0].
- Check byte: check = fold ^ (CHAIN_EN ? chain : 8'h00).
- Chain register, on accept: chain <= in_last ? SEED : check. Otherwise it holds.
- Buffer: 2-entry FIFO of {payload, check, last}. Push on accept, pop on emit.
- Outputs are driven from the FIFO head. out_valid = (count != 0).
- Latency: a payload accepted at edge N, into an empty FIFO, gives out_valid=1 with its frame after edge N. Minimum 1 cycle.
- in_ready is a register and equals (next_count < 2).
  - Full with a pop at edge N: in_ready=1 after edge N.
  - A push is never taken while in_ready=0.
- Simultaneous push and pop at count==1: count stays 1, new frame becomes head. No bubble and no loss.
- Throughput: 1 frame/cycle sustained when out_ready is held high.
- out_data and out_last hold stable while out_valid=1 and out_ready=0.
- frame_count increments on each emit and wraps 16'hFFFF -> 16'h0000.
- busy = (count != 0).
- Reset (synchronous, any cycle, including mid-burst with a full FIFO):
  - FIFO emptied, chain = SEED.
  - out_valid=0, out_data=0, out_last=0, frame_count=0, busy=0, in_ready=0 during reset.
  - in_ready=1 on the first cycle after reset deasserts.
  - Frames in flight are discarded. No partial frames after reset.
- out_valid never depends combinationally on out_ready. in_ready never depends combinationally on in_valid.
- X on in_data while in_valid=0 must not propagate to state.

Test Plan:
1. Reset, then CHAIN_EN=1, SEED=0. Send payload 56'h01, in_last=0, out_ready=1 -> out_data=64'h0000_0000_0000_0101, one cycle after accept; frame_count=1.
2. Same payload twice, in_last=0 on both -> frames 64'h...0101 then 64'h...0100 (chain 01^01=00). Repeat with in_last=1 on the first -> second frame 64'h...0101.
3. Payload 56'h01_02_03_04_05_06_07 with CHAIN_EN=0 -> out_data=64'h0102_0304_0506_0700 (fold=00). Payload 56'hFF -> check 8'hFF.
4. Backpressure: out_ready=0, in_valid=1 continuously -> exactly 2 accepts, then in_ready=0 and out_data stable. Raise out_ready for 1 cycle -> in_ready=1 the next cycle. Frames come out in order with none lost or duplicated.
5. Streaming with out_ready=1 and in_valid=1 for 100 cycles -> 99 frames emitted, one per cycle after the first. frame_count=99 at the end. Preload count=16'hFFFE via 65534 frames, then 3 more -> frame_count=1.
6. Assert reset with the FIFO full and chain != SEED -> next cycle out_valid=0 and frame_count=0. After release, in_ready=1 and the next frame with payload 56'h01 gives check 8'h01 (chain back to SEED).
